// File: rtl/pipe_pkg.sv
// Shared pipeline constants: load/store encodings, MA state encoding, register index width.
package pipe_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_LOAD  = 2'd1;
  localparam logic [1:0] RW_STORE = 2'd2;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  localparam logic [1:0] MA_IDLE = 2'd0;
  localparam logic [1:0] MA_MEM  = 2'd1;
  localparam logic [1:0] MA_HOLD = 2'd2;

  typedef struct packed {
    logic [1:0]           rw;
    logic [1:0]           len;
    logic                 uns;
    logic                 wb_e;
    logic [REG_IDX_W-1:0] wb_idx;
  } ma_ctl_t;

  // Reserved length 3 behaves as a word.
  function automatic logic misaligned(input logic [1:0] len, input logic [1:0] off);
    case (len)
      LEN_BYTE: misaligned = 1'b0;
      LEN_HALF: misaligned = off[0];
      default:  misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/pipe_ma_lane.sv
// Byte-lane logic for the MA stage: store byte enables / replicated write data,
// and load lane extraction with sign or zero extension.
module ma_lane
  import pipe_pkg::*;
(
  input  logic [1:0]  len_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_val_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o     = 4'hF;
    wdata_o  = st_data_i;
    ld_val_o = ld_word_i;
    byte_sel = ld_word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    case (len_i)
      LEN_BYTE: begin
        be_o     = 4'b0001 << off_i;
        wdata_o  = {4{st_data_i[7:0]}};
        ld_val_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      end
      // off[0] is ignored here, so an unchecked half at off=1 acts like off=0
      LEN_HALF: begin
        be_o     = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{st_data_i[15:0]}};
        ld_val_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      end
      default: begin
        be_o     = 4'hF;
        wdata_o  = st_data_i;
        ld_val_o = ld_word_i;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ma.sv
// Memory-access pipeline stage: one req/ack memory transaction per instruction,
// result held for WB. Optional misalignment trap enabled by MA_MISALIGN_CHK_EN.
module pipe_ma
  import pipe_pkg::*;
#(
  parameter int REG_SZ = 32,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_SZ-1:0]    ex_ans,
  input  logic [REG_SZ-1:0]    ex_dout,
  input  logic [1:0]           rw_e,
  input  logic [1:0]           rw_len,
  input  logic                 ld_uns,
  input  logic                 wb_e_in,
  input  logic [REG_IDX_W-1:0] wb_idx_in,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [REG_SZ-1:0]    mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [REG_SZ-1:0]    mem_rdata,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic                 wb_e_out,
  output logic [REG_IDX_W-1:0] wb_idx_out,
  output logic [REG_SZ-1:0]    wb_val,
  output logic [REG_IDX_W-1:0] MA_fwd_idx,
  output logic [REG_SZ-1:0]    MA_fwd_val,
  output logic                 misalign
);

  logic [1:0]        state_q, state_d;
  ma_ctl_t           ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_SZ-1:0] dout_q, dout_d;
  logic [REG_SZ-1:0] wb_val_q, wb_val_d;

  logic              acc_ls;
  logic              acc_mis;
  logic              acc_mem;
  logic [3:0]        lane_be;
  logic [REG_SZ-1:0] lane_wdata;
  logic [REG_SZ-1:0] lane_ld;

  assign acc_ls = (rw_e == RW_LOAD) || (rw_e == RW_STORE);

`ifdef MA_MISALIGN_CHK_EN
  assign acc_mis = acc_ls && misaligned(rw_len, ex_ans[1:0]);
`else
  assign acc_mis = 1'b0;
`endif

  assign acc_mem = acc_ls && !acc_mis;

  ma_lane u_lane (
    .len_i     (ctl_q.len),
    .off_i     (addr_q[1:0]),
    .uns_i     (ctl_q.uns),
    .st_data_i (dout_q),
    .ld_word_i (mem_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .ld_val_o  (lane_ld)
  );

  always_comb begin
    state_d  = state_q;
    ctl_d    = ctl_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    wb_val_d = wb_val_q;
    case (state_q)
      MA_IDLE: begin
        if (in_valid) begin
          ctl_d.rw     = rw_e;
          ctl_d.len    = rw_len;
          ctl_d.uns    = ld_uns;
          ctl_d.wb_e   = wb_e_in && !acc_mis && (rw_e != RW_STORE);
          ctl_d.wb_idx = wb_idx_in;
          addr_d       = ex_ans[ADDR_W-1:0];
          dout_d       = ex_dout;
          wb_val_d     = ex_ans;
          state_d      = acc_mem ? MA_MEM : MA_HOLD;
        end
      end
      MA_MEM: begin
        if (mem_ack) begin
          if (ctl_q.rw == RW_LOAD) wb_val_d = lane_ld;
          state_d = MA_HOLD;
        end
      end
      MA_HOLD: begin
        if (wb_ready) state_d = MA_IDLE;
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MA_IDLE;
      ctl_q    <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      wb_val_q <= '0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      wb_val_q <= wb_val_d;
    end
  end

  // Memory-side outputs are gated to zero outside MEM so an abandoned request leaves nothing behind.
  assign in_ready   = (state_q == MA_IDLE);
  assign mem_req    = (state_q == MA_MEM);
  assign mem_we     = mem_req && (ctl_q.rw == RW_STORE);
  assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be     = mem_req ? lane_be : 4'h0;
  assign mem_wdata  = mem_we ? lane_wdata : '0;

  assign wb_valid   = (state_q == MA_HOLD);
  assign wb_e_out   = ctl_q.wb_e;
  assign wb_idx_out = ctl_q.wb_idx;
  assign wb_val     = wb_val_q;

  assign MA_fwd_idx = (wb_valid && wb_e_out) ? wb_idx_out : '0;
  assign MA_fwd_val = wb_val_q;

`ifdef MA_MISALIGN_CHK_EN
  assign misalign = in_ready && in_valid && acc_mis;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ma.sv
// Self-checking bench for pipe_ma: directed cases plus randomized ops against an arithmetic reference model.
module tb_pipe_ma;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ex_ans, ex_dout;
  logic [1:0]  rw_e, rw_len;
  logic        ld_uns, wb_e_in;
  logic [4:0]  wb_idx_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_ready, wb_e_out;
  logic [4:0]  wb_idx_out, MA_fwd_idx;
  logic [31:0] wb_val, MA_fwd_val;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

`ifdef MA_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  pipe_ma #(.REG_SZ(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ex_ans(ex_ans), .ex_dout(ex_dout), .rw_e(rw_e), .rw_len(rw_len),
    .ld_uns(ld_uns), .wb_e_in(wb_e_in), .wb_idx_in(wb_idx_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_e_out(wb_e_out), .wb_idx_out(wb_idx_out), .wb_val(wb_val),
    .MA_fwd_idx(MA_fwd_idx), .MA_fwd_val(MA_fwd_val), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_mis(input logic [1:0] len, input logic [1:0] off);
    if (len == 2'd0) return 1'b0;
    if (len == 2'd1) return (off % 2) != 0;
    return off != 0;
  endfunction

  function automatic logic [31:0] model_be(input logic [1:0] len, input logic [1:0] off);
    if (len == 2'd0) return 32'(1 << off);
    if (len == 2'd1) return (off >= 2) ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] len, input logic [31:0] d);
    if (len == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (len == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] len, input logic [1:0] off,
                                             input logic uns, input logic [31:0] rd);
    logic [31:0] v;
    if (len == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (len == 2'd1) begin
      v = (rd >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic run_op(input logic [1:0] rw, input logic [1:0] len, input logic uns,
                        input logic [31:0] ans, input logic [31:0] dout, input logic wbe,
                        input logic [4:0] idx, input logic [31:0] rdata,
                        input int ack_dly, input int stall);
    bit          ls, mis, is_mem, is_load, exp_e;
    logic [31:0] exp_val;
    ls      = (rw == 2'd1) || (rw == 2'd2);
    mis     = CHK && ls && model_mis(len, ans[1:0]);
    is_mem  = ls && !mis;
    is_load = is_mem && (rw == 2'd1);
    exp_val = is_load ? model_load(len, ans[1:0], uns, rdata) : ans;
    exp_e   = wbe && !mis && (rw != 2'd2);

    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; rw_e = rw; rw_len = len; ld_uns = uns;
    ex_ans = ans; ex_dout = dout; wb_e_in = wbe; wb_idx_in = idx;
    mem_ack = 1'($urandom_range(0, 1));
    #1 check("misalign_at_accept", misalign, mis);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; mem_ack = 1'b0;
    ex_ans = $urandom; ex_dout = $urandom; rw_e = 2'($urandom); rw_len = 2'($urandom);
    ld_uns = 1'($urandom); wb_e_in = 1'($urandom); wb_idx_in = 5'($urandom);
    check("misalign_one_cycle", misalign, 0);
    check("in_ready_busy", in_ready, 0);

    if (is_mem) begin
      check("mem_req", mem_req, 1);
      check("mem_addr", mem_addr, ans & 32'hFFFF_FFFC);
      check("mem_we", mem_we, rw == 2'd2);
      check("mem_be", mem_be, model_be(len, ans[1:0]));
      if (rw == 2'd2) check("mem_wdata", mem_wdata, model_wdata(len, dout));
      check("wb_valid_in_mem", wb_valid, 0);
      check("fwd_idx_in_mem", MA_fwd_idx, 0);
      for (int i = 0; i < ack_dly; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("mem_req_held", mem_req, 1);
        check("mem_addr_held", mem_addr, ans & 32'hFFFF_FFFC);
        check("mem_be_held", mem_be, model_be(len, ans[1:0]));
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
    end else begin
      check("no_mem_req", mem_req, 0);
    end

    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
      end
      check("wb_valid", wb_valid, 1);
      check("in_ready_hold", in_ready, 0);
      check("mem_req_hold", mem_req, 0);
      check("wb_e_out", wb_e_out, exp_e);
      check("wb_idx_out", wb_idx_out, idx);
      check("fwd_idx", MA_fwd_idx, exp_e ? idx : 5'd0);
      if (!(is_mem && rw == 2'd2)) begin
        check("wb_val", wb_val, exp_val);
        check("fwd_val", MA_fwd_val, exp_val);
      end
    end
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_ready = 1'b0;
    check("wb_valid_drop", wb_valid, 0);
    check("in_ready_resume", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ex_ans = '0; ex_dout = '0; rw_e = '0; rw_len = '0;
    ld_uns = 1'b0; wb_e_in = 1'b0; wb_idx_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    wb_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_val", wb_val, 0);
    check("rst_wb_e_out", wb_e_out, 0);
    check("rst_fwd_idx", MA_fwd_idx, 0);
    check("rst_misalign", misalign, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(2'd0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 32'h0, 0, 0);
    run_op(2'd1, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 1'b1, 5'd7, 32'h80FF_0000, 3, 0);
    run_op(2'd1, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 1'b1, 5'd7, 32'h80FF_0000, 3, 0);
    run_op(2'd2, 2'd1, 1'b0, 32'h0000_0022, 32'hAAAA_BEEF, 1'b1, 5'd9, 32'h0, 1, 0);
    run_op(2'd1, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 5'd3, 32'hCAFE_F00D, 0, 4);
    run_op(2'd1, 2'd2, 1'b0, 32'h0000_0202, 32'h0, 1'b1, 5'd4, 32'h1357_9BDF, 1, 0);
    run_op(2'd2, 2'd1, 1'b0, 32'h0000_0311, 32'h1234_5678, 1'b1, 5'd6, 32'h0, 0, 1);
    run_op(2'd3, 2'd3, 1'b0, 32'h0000_0ABC, 32'h0, 1'b1, 5'd0, 32'h0, 0, 0);

    // Reset while a load is outstanding
    @(negedge clk);
    in_valid = 1'b1; rw_e = 2'd1; rw_len = 2'd2; ex_ans = 32'h0000_0500; wb_e_in = 1'b1;
    wb_idx_in = 5'd8;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_mem_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_wb_valid", wb_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2'd1, 2'd1, 1'b0, 32'h0000_0502, 32'h0, 1'b1, 5'd8, 32'h8001_7FFF, 2, 1);

    for (int n = 0; n < 60; n++) begin
      run_op(2'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
             5'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ma.md
Name: pipe_ma

Overview:
Memory-access stage, directly downstream of the execute stage. Accepts the ALU result, store data and load/store control from EX, and performs at most one memory transaction per instruction over a req/ack memory port. Produces the write-back value and index for WB, and drives the MA forwarding pair back to EX. Fully synchronous to clk: one FSM, no delay-based pulses.

Parameters:
REG_SZ, 32, datapath width; memory port data width equals REG_SZ (32 only is supported).
ADDR_W, 32, memory address width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  EX presents an instruction
in_ready  out  1  MA can accept this cycle
ex_ans  in  REG_SZ  ALU result; also the effective address for loads and stores
ex_dout  in  REG_SZ  store data
rw_e  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none)
rw_len  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word)
ld_uns  in  1  1 = zero-extend load, 0 = sign-extend load
wb_e_in  in  1  instruction writes a register
wb_idx_in  in  5  destination register
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
mem_wdata  out  REG_SZ  lane-replicated store data
mem_be  out  4  byte enables
mem_ack  in  1  request complete; rdata valid the same cycle
mem_rdata  in  REG_SZ  read word
wb_valid  out  1  result valid for WB
wb_ready  in  1  WB consumes the result
wb_e_out  out  1  write enable for WB (0 on misaligned access)
wb_idx_out  out  5  destination register
wb_val  out  REG_SZ  write-back value
MA_fwd_idx  out  5  forwarding index; 0 = none
MA_fwd_val  out  REG_SZ  forwarding value
misalign  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset: FSM enters IDLE. All outputs are 0 except in_ready, which is 1.
- FSM states:
  - IDLE: in_ready=1.
  - MEM: mem_req=1; in_ready=0.
  - HOLD: wb_valid=1; in_ready=0.
- IDLE, in_valid=1: latch all inputs.
  - rw_e is 1 or 2, and the access is aligned or MA_MISALIGN_CHK_EN is undefined: go to MEM.
  - Otherwise go to HOLD with wb_val=ex_ans.
- MEM: mem_addr, mem_we, mem_wdata and mem_be stay constant until mem_ack.
  - On mem_ack go to HOLD.
  - For a load, wb_val = extended lane of mem_rdata, registered.
  - For a store, wb_e_out is forced to 0.
- HOLD: wb_valid=1. When wb_ready=1, go to IDLE.
- Throughput is one instruction every 2 cycles, or more; there is no bypass from HOLD to accept.
- Latency:
  - Non-memory instruction: accepted in cycle N, wb_valid in cycle N+1.
  - Memory instruction: mem_req rises in N+1; wb_valid in the cycle after ack.
- Store lanes, with off = addr[1:0]:
  - byte: be = 1<<off; wdata = the byte replicated into all 4 lanes.
  - half: be = 0011 when off=0, 1100 when off=2; wdata = the half replicated.
  - word: be = 1111; wdata = ex_dout.
- Load extract: take byte lane off or half lane off[1], then sign- or zero-extend per ld_uns.
- Alignment: half requires off[0]=0; word requires off=0.
- Forwarding: MA_fwd_idx = wb_idx_out when (wb_valid && wb_e_out), else 0. MA_fwd_val = wb_val. MA_fwd_idx is never nonzero while in MEM.
- A value of 0 for wb_idx_in is carried through unchanged; WB ignores it.
- mem_ack outside MEM is ignored.
- rst asserted mid-transaction drops mem_req immediately (asynchronous). The memory side must tolerate an abandoned request.

Optional Feature:
MA_MISALIGN_CHK_EN.
- Defined: a misaligned load or store issues no memory request. misalign pulses for 1 cycle at accept; the stage goes to HOLD with wb_e_out=0 and wb_val=ex_ans.
- Undefined: no check is made. misalign is tied 0. addr[1:0] is used as-is for lane selection, and a misaligned half or word uses be/extraction computed from the truncated offset (half at off=1 behaves as off=0; word ignores off).

Decomposition:
- Shared package pipe_pkg:
  - RW_NONE/RW_LOAD/RW_STORE and LEN_BYTE/LEN_HALF/LEN_WORD constants.
  - FSM state encoding MA_IDLE/MA_MEM/MA_HOLD.
  - Register-index width constant 5.
- One sub-module, ma_lane: combinational store be/wdata generation and load extract/extend, instantiated once.

Test Plan:
- ALU op: ex_ans=0x1234, wb_e_in=1, wb_idx_in=5, rw_e=0 -> wb_valid one cycle after accept, wb_val=0x1234, MA_fwd_idx=5, no mem_req.
- Load byte, signed: addr 0x103, mem_rdata=0x80FF_0000, ack after 3 cycles -> mem_addr=0x100, mem_be=1000, wb_val=0xFFFF_FF80. Same load with ld_uns=1 -> 0x0000_0080.
- Store half: addr 0x22, ex_dout=0xAAAA_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF, wb_e_out=0, MA_fwd_idx=0.
- Backpressure: wb_ready=0 for 4 cycles -> wb_valid and wb_val stable; in_ready=0 throughout; accept resumes the cycle after wb_ready=1.
- Misaligned word at 0x202 with MA_MISALIGN_CHK_EN -> no mem_req, misalign pulses once, wb_e_out=0.
- rst pulsed while in MEM -> mem_req=0 asynchronously, in_ready=1, wb_valid=0; the next accepted op completes normally.
